// File: rtl/ahb_master_req.sv
// AHB bus-master request engine: turns a local {addr, len, lock} request into
// an INCR burst of word transfers, re-arbitrating after grant loss and
// restarting with NONSEQ at 1KB boundaries and address wrap.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   S_IDLE  | waiting for req_valid; req_ready high
//   S_REQ   | bus requested, waiting for hgrant & hready
//   S_ACT   | driving address phases (NONSEQ/SEQ) until the last beat
//   S_DLAST | data phase of the final beat; done pulses when it completes
module ahb_master_req #(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 5
) (
    input  logic              hclk,
    input  logic              hresetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic              req_lock,
    output logic              hbusreq,
    output logic              hlock,
    input  logic              hgrant,
    input  logic              hready,
    output logic [1:0]        htrans,
    output logic [ADDR_W-1:0] haddr,
    output logic [2:0]        hburst,
    output logic [2:0]        hsize,
    output logic              done
);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_ACT   = 2'd2,
        S_DLAST = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [4:0]        rem_q, rem_d;
    logic              restart_q, restart_d;
    logic              lock_q, lock_d;
    logic              done_q, done_d;

    logic [4:0]        len_norm;
    logic [ADDR_W:0]   addr_sum;
    logic [ADDR_W-1:0] addr_inc;
    logic              addr_wrap;
    logic              kb_cross;

    assign hburst = 3'b001;
    assign hsize  = 3'b010;
    assign done   = done_q;

    // Clamp the requested beat count into 1..16.
    always_comb begin
        len_norm = 5'd16;
        if (req_len == '0) begin
            len_norm = 5'd1;
        end else if (32'(req_len) <= 32'd16) begin
            len_norm = 5'(req_len);
        end
    end

    // Next word address; the carry out flags a wrap through zero.
    always_comb begin
        addr_sum  = {1'b0, addr_q} + (ADDR_W+1)'(4);
        addr_inc  = addr_sum[ADDR_W-1:0];
        addr_wrap = addr_sum[ADDR_W];
        kb_cross  = (addr_inc[9:0] == 10'd0);
    end

    // Next-state, counters and bus outputs.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        restart_d = restart_q;
        lock_d    = lock_q;
        done_d    = 1'b0;
        req_ready = 1'b0;
        hbusreq   = 1'b0;
        hlock     = 1'b0;
        htrans    = HTRANS_IDLE;
        haddr     = addr_q;

        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    addr_d    = req_addr & ~ADDR_W'(3);
                    rem_d     = len_norm;
                    lock_d    = req_lock;
                    restart_d = 1'b1;
                    state_d   = S_REQ;
                end
            end
            S_REQ: begin
                hbusreq = 1'b1;
                hlock   = lock_q;
                if (hgrant && hready) begin
                    state_d = S_ACT;
                end
            end
            S_ACT: begin
                hbusreq = 1'b1;
                hlock   = lock_q;
                htrans  = restart_q ? HTRANS_NONSEQ : HTRANS_SEQ;
                if (hready) begin
                    addr_d    = addr_inc;
                    rem_d     = rem_q - 5'd1;
                    restart_d = kb_cross | addr_wrap;
                    if (rem_q == 5'd1) begin
                        state_d = S_DLAST;
                    end else if (!hgrant) begin
                        // Bus lost: re-arbitrate and resume with a fresh NONSEQ.
                        state_d   = S_REQ;
                        restart_d = 1'b1;
                    end
                end
            end
            S_DLAST: begin
                hlock = lock_q;
                if (hready) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            rem_q     <= 5'd0;
            restart_q <= 1'b1;
            lock_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            restart_q <= restart_d;
            lock_q    <= lock_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: doc/ahb_master_req.md
AHB_MASTER_REQ -- requirements
Module: ahb_master_req

Interface
REQ-001 Parameter ADDR_W, default 32, width of the address path.
REQ-002 Parameter LEN_W, default 5, width of the beat-count field.
REQ-003 hclk  in  1  single clock; all state changes on its rising edge.
REQ-004 hresetn  in  1  reset, synchronous, active-low.
REQ-005 req_valid  in  1  local transfer request.
REQ-006 req_ready  out  1  high exactly when state is IDLE; request accepted on req_valid&req_ready.
REQ-007 req_addr  in  ADDR_W  start address, word aligned (bits[1:0] ignored, forced 0).
REQ-008 req_len  in  LEN_W  beat count 1..16; 0 treated as 1; values above 16 treated as 16.
REQ-009 req_lock  in  1  request a locked sequence.
REQ-010 hbusreq  out  1  bus request to the arbiter.
REQ-011 hlock  out  1  lock request to the arbiter.
REQ-012 hgrant  in  1  this master's grant bit from the arbiter.
REQ-013 hready  in  1  AHB transfer-ready.
REQ-014 htrans  out  2  IDLE=00, NONSEQ=10, SEQ=11; BUSY never driven.
REQ-015 haddr  out  ADDR_W  address-phase address.
REQ-016 hburst  out  3  constant INCR (001).
REQ-017 hsize  out  3  constant word (010).
REQ-018 done  out  1  one-cycle pulse when the final beat's data phase completes.

Function
REQ-019 States: IDLE, REQ, ACT, DLAST; registered.
REQ-020 IDLE: htrans=IDLE, hbusreq=0, hlock=0. On req_valid, latch addr, len and lock, and set restart=1; next state REQ.
REQ-021 REQ: hbusreq=1, hlock=latched lock, htrans=IDLE. Edge with hgrant&hready=1 -> ACT; otherwise stay.
REQ-022 ACT: hbusreq=1, haddr=current address, htrans=NONSEQ if restart=1, else SEQ.
REQ-023 ACT, edge with hready=1 (beat accepted): address+=4, remaining-=1, restart cleared.
REQ-024 ACT, edge with hready=0: all outputs held, no counter change.
REQ-025 If remaining reaches 0 on acceptance -> DLAST.
REQ-026 Else if hgrant=0 at the accepting edge (bus lost) -> REQ with restart=1; address and remaining preserved.
REQ-027 Else stay in ACT.
REQ-028 1KB boundary: if the incremented address has bits[9:0]=0, set restart=1 so the next beat is NONSEQ.
REQ-029 Address arithmetic is modulo 2^ADDR_W; wrap from all-ones to 0 also sets restart=1.
REQ-030 DLAST: htrans=IDLE, hbusreq=0, hlock held at latched lock. Edge with hready=1 -> IDLE with done=1 for exactly that next cycle.
REQ-031 hlock stays asserted from REQ through DLAST, including across a grant loss, and drops in IDLE.
REQ-032 req_valid is ignored outside IDLE.
REQ-033 Latency: request accepted at edge N gives hbusreq=1 in cycle N+1; a granted, zero-wait single beat gives done high 4 cycles after acceptance.

Reset
REQ-034 hresetn=0 sampled at an edge, in any state (mid-burst included), forces the following values at that edge: state IDLE, hbusreq=0, hlock=0, htrans=IDLE, haddr=0, done=0, remaining=0, restart=1, req_ready=1; hburst=001 and hsize=010 always.
REQ-035 A pending request is discarded by reset; no done pulse is produced for it.

Verification
REQ-036 Single beat: addr 0x100, len 1, hgrant=1, hready=1 -> one NONSEQ at 0x100, hbusreq low in DLAST, one done pulse.
REQ-037 Burst: addr 0x2000, len 4, zero wait -> NONSEQ 0x2000, SEQ 0x2004/0x2008/0x200C, then IDLE and done.
REQ-038 Wait states: hready low 2 cycles during beat 2 of len 3 -> htrans and haddr held; the beat sequence is unchanged.
REQ-039 Grant loss: len 4 at 0x40, hgrant drops after beat 2 accepted -> back to REQ with hbusreq=1; on regrant, NONSEQ 0x48 then SEQ 0x4C.
REQ-040 1KB cross: addr 0x3F8, len 4 -> NONSEQ 0x3F8, SEQ 0x3FC, NONSEQ 0x400, SEQ 0x404.
REQ-041 Reset in ACT with len 8 and remaining 5 -> next cycle all outputs at reset values, no done, req_ready=1.
